// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 core: fetch FSM encoding and program-counter constants.
package chip8_pkg;

    typedef enum logic [1:0] {
        S_ADDR_HI  = 2'd0,
        S_LATCH_HI = 2'd1,
        S_LATCH_LO = 2'd2,
        S_VALID    = 2'd3
    } fetch_state_e;

    localparam logic [11:0] RESET_PC     = 12'h200;
    localparam logic [11:0] FONT_BASE    = 12'h000;
    localparam int unsigned PC_STEP      = 2;
    localparam int unsigned PC_SKIP_STEP = 4;

endpackage

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: reads two bytes from a 1-cycle sync memory, presents the big-endian
// opcode over valid/ready, and applies redirects and skips from execute.
module chip8_fetch #(
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(chip8_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              halt,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [15:0]       opcode,
    output logic [ADDR_W-1:0] op_pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic              pc_skip
);
    import chip8_pkg::*;

    localparam logic [ADDR_W-1:0] BYTE_STEP = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OP_STEP   = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] SKIP_STEP = ADDR_W'(PC_SKIP_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] op_pc_q, op_pc_d;
    logic [15:0]       opcode_q, opcode_d;
    logic              op_valid_q, op_valid_d;

    // The low byte is requested while the high byte's data is arriving.
    assign mem_addr = (state_q == S_LATCH_HI) ? pc_q + BYTE_STEP : pc_q;
    assign op_valid = op_valid_q;
    assign opcode   = opcode_q;
    assign op_pc    = op_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op_pc_d    = op_pc_q;
        opcode_d   = opcode_q;
        op_valid_d = op_valid_q;

        case (state_q)
            S_ADDR_HI: begin
                if (pc_load) begin
                    pc_d = pc_load_val;
                end else if (!halt) begin
                    state_d = S_LATCH_HI;
                end
            end
            S_LATCH_HI: begin
                if (pc_load) begin
                    pc_d    = pc_load_val;
                    state_d = S_ADDR_HI;
                end else begin
                    opcode_d[15:8] = mem_data;
                    state_d        = S_LATCH_LO;
                end
            end
            S_LATCH_LO: begin
                if (pc_load) begin
                    pc_d    = pc_load_val;
                    state_d = S_ADDR_HI;
                end else begin
                    opcode_d[7:0] = mem_data;
                    op_pc_d       = pc_q;
                    op_valid_d    = 1'b1;
                    state_d       = S_VALID;
                end
            end
            S_VALID: begin
                // Redirects and skips only take effect together with the handshake.
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = S_ADDR_HI;
                    if (pc_load) begin
                        pc_d = pc_load_val;
                    end else if (pc_skip) begin
                        pc_d = pc_q + SKIP_STEP;
                    end else begin
                        pc_d = pc_q + OP_STEP;
                    end
                end
            end
            default: state_d = S_ADDR_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_ADDR_HI;
            pc_q       <= RESET_PC;
            op_pc_q    <= RESET_PC;
            opcode_q   <= 16'h0000;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_pc_q    <= op_pc_d;
            opcode_q   <= opcode_d;
            op_valid_q <= op_valid_d;
        end
    end

endmodule
